// File: rtl/ysyx_25060170_pkg.sv
// Purpose: shared types and constants for the ysyx_25060170 instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ysyx_25060170_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // addi x0, x0, 0 -- substituted for faulted fetches so IDU never decodes garbage
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } ifu_state_e;

  // Fetch addresses are always word aligned; low bits of a target are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/ysyx_25060170_pc_reg.sv
// Purpose: architectural PC register with redirect-over-increment priority.
// Latency: next PC visible one cycle after redirect_valid or advance.
// Backpressure: none; holds its value when neither redirect nor advance is asserted.
//
// Ports:
//   clk, rst        core clock, async active-low reset (pc <= RESET_PC)
//   redirect_valid  load word-aligned redirect_pc (wins over advance)
//   redirect_pc     redirect target, bits [1:0] ignored
//   advance         step pc by 4 (modulo 2^32)
//   pc              current PC
module ysyx_25060170_pc_reg
  import ysyx_25060170_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            advance,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_next;

  always_comb begin
    pc_next = pc;
    if (redirect_valid) begin
      pc_next = word_align(redirect_pc);
    end else if (advance) begin
      pc_next = pc + 32'd4;  // wraps naturally at 2^32
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/ysyx_25060170_ifu.sv
// Purpose: instruction fetch unit; owns PC, fetches words from imem, presents {pc, inst} to IDU.
// Latency: 3 cycles per instruction with zero-wait memory (REQ, WAIT, OUT); one request outstanding.
// Backpressure: holds the presented instruction and issues no new request while inst_ready_i is low.
//
// Ports:
//   clk, rst                          core clock, async active-low reset
//   imem_req_valid_o/ready_i/addr_o   fetch request channel (addr = pc)
//   imem_resp_valid_i/rdata_i/err_i   fetch response, one pulse per accepted request
//   redirect_valid_i/pc_i             WBU control-flow redirect
//   inst_valid_o/ready_i              handshake toward IDU carrying pc_o, inst_o, fetch_err_o
//   fetch_cnt_o                       instructions accepted by IDU (wrapping)
module ysyx_25060170_ifu
  import ysyx_25060170_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_resp_valid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            imem_resp_err_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] inst_o,
  output logic            fetch_err_o,
  output logic [31:0]     fetch_cnt_o
);

  ifu_state_e      state;
  logic            kill;
  logic            advance;
  logic [XLEN-1:0] pc;

  // Only an accepted, non-redirected instruction moves the PC forward.
  assign advance = (state == OUT) && inst_ready_i && !redirect_valid_i;

  ysyx_25060170_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid_i),
    .redirect_pc    (redirect_pc_i),
    .advance        (advance),
    .pc             (pc)
  );

  // pc is a flop, so the address is registered and tracks a redirect one cycle later.
  assign imem_addr_o = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      kill             <= 1'b0;
      imem_req_valid_o <= 1'b0;
      inst_valid_o     <= 1'b0;
      pc_o             <= RESET_PC;
      inst_o           <= '0;
      fetch_err_o      <= 1'b0;
      fetch_cnt_o      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state            <= REQ;
          imem_req_valid_o <= 1'b1;
        end
        REQ: begin
          if (imem_req_ready_i) begin
            state            <= WAIT;
            imem_req_valid_o <= 1'b0;
            // request already left with the old pc; its response must be discarded
            kill             <= redirect_valid_i;
          end
        end
        WAIT: begin
          if (kill || redirect_valid_i) begin
            if (imem_resp_valid_i) begin
              state            <= REQ;
              imem_req_valid_o <= 1'b1;
              kill             <= 1'b0;
            end else begin
              kill <= 1'b1;
            end
          end else if (imem_resp_valid_i) begin
            state        <= OUT;
            inst_valid_o <= 1'b1;
            pc_o         <= pc;
            inst_o       <= imem_resp_err_i ? NOP_INST : imem_rdata_i;
            fetch_err_o  <= imem_resp_err_i;
          end
        end
        OUT: begin
          if (redirect_valid_i || inst_ready_i) begin
            state            <= REQ;
            imem_req_valid_o <= 1'b1;
            inst_valid_o     <= 1'b0;
            // a redirect squashes the held instruction even if IDU takes it this cycle
            if (!redirect_valid_i) begin
              fetch_cnt_o <= fetch_cnt_o + 32'd1;
            end
          end
        end
        default: begin
          state            <= IDLE;
          imem_req_valid_o <= 1'b0;
          inst_valid_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25060170_ifu.sv
// Purpose: directed self-checking bench for ysyx_25060170_ifu.
// Latency: stimulus stepped one clock at a time; outputs sampled 1 time unit after each rising edge.
// Backpressure: IDU ready and imem ready driven explicitly per scenario.
module tb_ysyx_25060170_ifu;

  logic        clk;
  logic        rst;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_resp_valid_i;
  logic [31:0] imem_rdata_i;
  logic        imem_resp_err_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        fetch_err_o;
  logic [31:0] fetch_cnt_o;

  int checks;
  int errors;

  ysyx_25060170_ifu dut (
    .clk               (clk),
    .rst               (rst),
    .imem_req_valid_o  (imem_req_valid_o),
    .imem_req_ready_i  (imem_req_ready_i),
    .imem_addr_o       (imem_addr_o),
    .imem_resp_valid_i (imem_resp_valid_i),
    .imem_rdata_i      (imem_rdata_i),
    .imem_resp_err_i   (imem_resp_err_i),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_pc_i     (redirect_pc_i),
    .inst_valid_o      (inst_valid_o),
    .inst_ready_i      (inst_ready_i),
    .pc_o              (pc_o),
    .inst_o            (inst_o),
    .fetch_err_o       (fetch_err_o),
    .fetch_cnt_o       (fetch_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    imem_req_ready_i = 1'b0; imem_resp_valid_i = 1'b0; imem_rdata_i = '0; imem_resp_err_i = 1'b0;
    redirect_valid_i = 1'b0; redirect_pc_i = '0; inst_ready_i = 1'b0;
    tick(); tick();
    checks++; if (imem_req_valid_o !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid_o); end
    checks++; if (imem_addr_o !== 32'h8000_0000) begin errors++; $display("FAIL rst_addr: got %h want 80000000", imem_addr_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid_o); end
    checks++; if (pc_o !== 32'h8000_0000) begin errors++; $display("FAIL rst_pc_o: got %h want 80000000", pc_o); end
    checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL rst_inst_o: got %h want 0", inst_o); end
    checks++; if (fetch_err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", fetch_err_o); end
    checks++; if (fetch_cnt_o !== 32'h0) begin errors++; $display("FAIL rst_cnt: got %h want 0", fetch_cnt_o); end
    rst = 1'b1;
  endtask

  // IDLE -> REQ -> WAIT -> OUT with ready high and a one-cycle response.
  task automatic test_first_fetch();
    imem_req_ready_i = 1'b1;
    tick();
    checks++; if (imem_req_valid_o !== 1'b1 || imem_addr_o !== 32'h8000_0000) begin errors++; $display("FAIL first_req: got v=%b a=%h want v=1 a=80000000", imem_req_valid_o, imem_addr_o); end
    tick();
    imem_req_ready_i = 1'b0;
    imem_resp_valid_i = 1'b1; imem_rdata_i = 32'h0050_0093;
    checks++; if (inst_valid_o !== 1'b0 || imem_req_valid_o !== 1'b0) begin errors++; $display("FAIL first_wait: got iv=%b rv=%b want 0 0", inst_valid_o, imem_req_valid_o); end
    tick();
    imem_resp_valid_i = 1'b0; imem_rdata_i = 32'hFFFF_FFFF;
    checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL first_valid: got %b want 1", inst_valid_o); end
    checks++; if (pc_o !== 32'h8000_0000 || inst_o !== 32'h0050_0093) begin errors++; $display("FAIL first_data: got pc=%h inst=%h want 80000000 00500093", pc_o, inst_o); end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h8000_0000 || inst_o !== 32'h0050_0093 || fetch_err_o !== 1'b0 || imem_req_valid_o !== 1'b0) begin errors++; $display("FAIL hold_stable[%0d]: got iv=%b pc=%h inst=%h err=%b rv=%b", i, inst_valid_o, pc_o, inst_o, fetch_err_o, imem_req_valid_o); end
    end
    inst_ready_i = 1'b1;
    tick();
    inst_ready_i = 1'b0;
    checks++; if (fetch_cnt_o !== 32'd1) begin errors++; $display("FAIL hold_cnt: got %0d want 1", fetch_cnt_o); end
    checks++; if (imem_addr_o !== 32'h8000_0004 || imem_req_valid_o !== 1'b1 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL hold_next_req: got a=%h rv=%b iv=%b want 80000004 1 0", imem_addr_o, imem_req_valid_o, inst_valid_o); end
  endtask

  task automatic test_redirect_wait();
    imem_req_ready_i = 1'b1;
    tick();
    imem_req_ready_i = 1'b0;
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h8000_0103;
    tick();
    redirect_valid_i = 1'b0;
    imem_resp_valid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid_i = 1'b0;
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rdw_stale_dropped: got iv=%b want 0", inst_valid_o); end
    checks++; if (imem_req_valid_o !== 1'b1 || imem_addr_o !== 32'h8000_0100) begin errors++; $display("FAIL rdw_req: got v=%b a=%h want 1 80000100", imem_req_valid_o, imem_addr_o); end
    imem_req_ready_i = 1'b1;
    tick();
    imem_req_ready_i = 1'b0;
    imem_resp_valid_i = 1'b1; imem_rdata_i = 32'h0010_0113;
    tick();
    imem_resp_valid_i = 1'b0;
    checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h8000_0100 || inst_o !== 32'h0010_0113) begin errors++; $display("FAIL rdw_out: got iv=%b pc=%h inst=%h want 1 80000100 00100113", inst_valid_o, pc_o, inst_o); end
    inst_ready_i = 1'b1;
    tick();
    inst_ready_i = 1'b0;
    checks++; if (fetch_cnt_o !== 32'd2 || imem_addr_o !== 32'h8000_0104) begin errors++; $display("FAIL rdw_after: got cnt=%0d a=%h want 2 80000104", fetch_cnt_o, imem_addr_o); end
  endtask

  // Redirect while the request is still waiting for imem ready.
  task automatic test_redirect_req();
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h9000_0002;
    tick();
    redirect_valid_i = 1'b0;
    checks++; if (imem_req_valid_o !== 1'b1 || imem_addr_o !== 32'h9000_0000) begin errors++; $display("FAIL rdr_addr: got v=%b a=%h want 1 90000000", imem_req_valid_o, imem_addr_o); end
    imem_req_ready_i = 1'b1;
    tick();
    imem_req_ready_i = 1'b0;
    imem_resp_valid_i = 1'b1; imem_rdata_i = 32'h0000_0073;
    tick();
    imem_resp_valid_i = 1'b0;
    checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h9000_0000 || inst_o !== 32'h0000_0073) begin errors++; $display("FAIL rdr_out: got iv=%b pc=%h inst=%h want 1 90000000 00000073", inst_valid_o, pc_o, inst_o); end
  endtask

  // Redirect in OUT together with IDU ready: instruction squashed, not counted.
  task automatic test_redirect_out();
    inst_ready_i = 1'b1;
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h8000_0200;
    tick();
    inst_ready_i = 1'b0; redirect_valid_i = 1'b0;
    checks++; if (fetch_cnt_o !== 32'd2) begin errors++; $display("FAIL rdo_cnt: got %0d want 2", fetch_cnt_o); end
    checks++; if (inst_valid_o !== 1'b0 || imem_req_valid_o !== 1'b1 || imem_addr_o !== 32'h8000_0200) begin errors++; $display("FAIL rdo_req: got iv=%b rv=%b a=%h want 0 1 80000200", inst_valid_o, imem_req_valid_o, imem_addr_o); end
  endtask

  task automatic test_fetch_err();
    imem_req_ready_i = 1'b1;
    tick();
    imem_req_ready_i = 1'b0;
    imem_resp_valid_i = 1'b1; imem_resp_err_i = 1'b1; imem_rdata_i = 32'h1234_5678;
    tick();
    imem_resp_valid_i = 1'b0; imem_resp_err_i = 1'b0;
    checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_0013 || fetch_err_o !== 1'b1 || pc_o !== 32'h8000_0200) begin errors++; $display("FAIL err_out: got iv=%b inst=%h err=%b pc=%h want 1 00000013 1 80000200", inst_valid_o, inst_o, fetch_err_o, pc_o); end
    inst_ready_i = 1'b1;
    tick();
    inst_ready_i = 1'b0;
    checks++; if (fetch_cnt_o !== 32'd3 || imem_addr_o !== 32'h8000_0204) begin errors++; $display("FAIL err_next: got cnt=%0d a=%h want 3 80000204", fetch_cnt_o, imem_addr_o); end
    imem_req_ready_i = 1'b1;
    tick();
    imem_req_ready_i = 1'b0;
    imem_resp_valid_i = 1'b1; imem_rdata_i = 32'h0000_0513;
    tick();
    imem_resp_valid_i = 1'b0;
    checks++; if (fetch_err_o !== 1'b0 || inst_o !== 32'h0000_0513 || pc_o !== 32'h8000_0204) begin errors++; $display("FAIL err_clear: got err=%b inst=%h pc=%h want 0 00000513 80000204", fetch_err_o, inst_o, pc_o); end
    inst_ready_i = 1'b1;
    tick();
    inst_ready_i = 1'b0;
  endtask

  task automatic test_pc_wrap();
    redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFD;
    tick();
    redirect_valid_i = 1'b0;
    checks++; if (imem_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h want fffffffc", imem_addr_o); end
    imem_req_ready_i = 1'b1;
    tick();
    imem_req_ready_i = 1'b0;
    imem_resp_valid_i = 1'b1; imem_rdata_i = 32'h0000_0093;
    tick();
    imem_resp_valid_i = 1'b0;
    inst_ready_i = 1'b1;
    tick();
    inst_ready_i = 1'b0;
    checks++; if (imem_addr_o !== 32'h0 || fetch_cnt_o !== 32'd5) begin errors++; $display("FAIL wrap_next: got a=%h cnt=%0d want 00000000 5", imem_addr_o, fetch_cnt_o); end
  endtask

  // Reset during WAIT; the in-flight response lands in IDLE and must be ignored.
  task automatic test_reset_mid();
    imem_req_ready_i = 1'b1;
    tick();
    imem_req_ready_i = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (imem_req_valid_o !== 1'b0 || imem_addr_o !== 32'h8000_0000 || fetch_cnt_o !== 32'h0 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_async: got rv=%b a=%h cnt=%0d iv=%b want 0 80000000 0 0", imem_req_valid_o, imem_addr_o, fetch_cnt_o, inst_valid_o); end
    tick(); tick();
    rst = 1'b1;
    imem_resp_valid_i = 1'b1; imem_rdata_i = 32'hBAD0_BAD0;
    checks++; if (pc_o !== 32'h8000_0000 || inst_o !== 32'h0 || fetch_err_o !== 1'b0) begin errors++; $display("FAIL midrst_outs: got pc=%h inst=%h err=%b want 80000000 0 0", pc_o, inst_o, fetch_err_o); end
    tick();
    imem_resp_valid_i = 1'b0;
    checks++; if (imem_req_valid_o !== 1'b1 || imem_addr_o !== 32'h8000_0000 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_restart: got rv=%b a=%h iv=%b want 1 80000000 0", imem_req_valid_o, imem_addr_o, inst_valid_o); end
    tick();
    checks++; if (imem_req_valid_o !== 1'b1 || inst_valid_o !== 1'b0 || inst_o !== 32'h0) begin errors++; $display("FAIL midrst_ignored: got rv=%b iv=%b inst=%h want 1 0 00000000", imem_req_valid_o, inst_valid_o, inst_o); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_first_fetch();
    test_hold();
    test_redirect_wait();
    test_redirect_req();
    test_redirect_out();
    test_fetch_err();
    test_pc_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
